i2c_slave: RTL

- I2C target (responder) for the bus driven by the team's i2c_master: 7-bit address, single- and multi-byte write and read.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain for ACK and read data.
- Presents received bytes to, and fetches transmit bytes from, a local host over a simple pulse/strobe interface.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_slave_if.sv | 15 +
 rtl/i2c_line_sync.sv | 56 +++++
 rtl/i2c_slave.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// bus-level constants and the width of the per-byte bit counter.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

  localparam int BIT_CNT_W = 4;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Host-side handshake of the I2C target: received bytes go out with a
// one-clk valid pulse, transmit bytes are requested with a one-clk pulse.
interface i2c_slave_if;

  logic [7:0] rx_dat;
  logic       rx_valid;
  logic [7:0] tx_dat;
  logic       tx_req;
  logic       selected;
  logic       busy;

  modport slave  (output rx_dat, rx_valid, tx_req, selected, busy, input tx_dat);
  modport master (input rx_dat, rx_valid, tx_req, selected, busy, output tx_dat);

endinterface

// File: rtl/i2c_line_sync.sv
// Synchroniser for one I2C bus line with rise/fall strobes.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter
// after the synchroniser, rejecting 1-clk pulses at a cost of 2 clk latency.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev_q;

  // Metastability chain; resets to 1 to match an idle, pulled-up bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Majority of the current and two previous samples; a lone 1-clk pulse never wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], synced};
      filt_q <= (synced & hist_q[0]) | (synced & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign level = filt_q;
`else
  assign level = synced;
`endif

  // Previous level for edge detection on the cleaned-up line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address, multi-byte write and read, open-drain SDA.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN enables majority filtering of SCL/SDA.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scl,
  inout  wire             sda,
  i2c_slave_if.slave      host
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_t state, state_nxt;
  bit_cnt_t   bit_cnt, bit_cnt_nxt;
  logic [6:0] shift, shift_nxt;
  logic [6:0] tx_shift, tx_shift_nxt;
  logic [7:0] shift_in;
  logic [7:0] rx_dat, rx_dat_nxt;
  logic       rx_valid, rx_valid_nxt;
  logic       tx_req, tx_req_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic       selected, selected_nxt;
  logic       busy, busy_nxt;
  logic       rw, rw_nxt;
  logic       read_ack;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .din(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .din(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign shift_in  = {shift, sda_lvl};
  assign read_ack  = (state == ADDR_ACK) && (rw == I2C_RW_READ);

  assign sda           = sda_oe ? 1'b0 : 1'bz;
  assign host.rx_dat   = rx_dat;
  assign host.rx_valid = rx_valid;
  assign host.tx_req   = tx_req;
  assign host.selected = selected;
  assign host.busy     = busy;

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_shift <= '0;
      rx_dat   <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      sda_oe   <= 1'b0;
      selected <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      tx_shift <= tx_shift_nxt;
      rx_dat   <= rx_dat_nxt;
      rx_valid <= rx_valid_nxt;
      tx_req   <= tx_req_nxt;
      sda_oe   <= sda_oe_nxt;
      selected <= selected_nxt;
      busy     <= busy_nxt;
      rw       <= rw_nxt;
    end
  end

  // Next-state logic; STOP overrides START, both override the per-state action.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    tx_shift_nxt = tx_shift;
    rx_dat_nxt   = rx_dat;
    rx_valid_nxt = 1'b0;
    tx_req_nxt   = 1'b0;
    sda_oe_nxt   = sda_oe;
    selected_nxt = selected;
    busy_nxt     = busy;
    rw_nxt       = rw;

    case (state)
      IDLE: ;
      ADDR: begin
        if (scl_rise) begin
          shift_nxt = shift_in[6:0];
          if (bit_cnt == 4'd7) begin
            bit_cnt_nxt = '0;
            if (shift_in[7:1] == SLAVE_ADDR && shift_in[7:1] != 7'd0) begin
              state_nxt    = ADDR_ACK;
              selected_nxt = 1'b1;
              rw_nxt       = shift_in[0];
            end else begin
              state_nxt = WAIT_STOP;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ADDR_ACK, RX_ACK: begin
        if (scl_fall && bit_cnt == 4'd0) begin
          sda_oe_nxt  = 1'b1;
          bit_cnt_nxt = 4'd1;
        end else if (scl_fall) begin
          bit_cnt_nxt = '0;
          if (read_ack) begin
            state_nxt    = TX;
            tx_shift_nxt = host.tx_dat[6:0];
            sda_oe_nxt   = (host.tx_dat[7] == 1'b0);
          end else begin
            state_nxt  = RX;
            sda_oe_nxt = 1'b0;
          end
        end else if (scl_rise && read_ack) begin
          tx_req_nxt = 1'b1;
        end
      end
      RX: begin
        if (scl_rise) begin
          shift_nxt = shift_in[6:0];
          if (bit_cnt == 4'd7) begin
            rx_dat_nxt   = shift_in;
            rx_valid_nxt = 1'b1;
            bit_cnt_nxt  = '0;
            state_nxt    = RX_ACK;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      TX: begin
        if (scl_fall) begin
          if (bit_cnt == 4'd7) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = TX_ACK;
          end else begin
            bit_cnt_nxt  = bit_cnt + 1'b1;
            sda_oe_nxt   = (tx_shift[6] == 1'b0);
            tx_shift_nxt = {tx_shift[5:0], 1'b0};
          end
        end
      end
      TX_ACK: begin
        if (scl_rise && bit_cnt == 4'd0) begin
          if (sda_lvl == I2C_ACK) begin
            tx_req_nxt  = 1'b1;
            bit_cnt_nxt = 4'd1;
          end else begin
            state_nxt    = WAIT_STOP;
            selected_nxt = 1'b0;
          end
        end else if (scl_fall && bit_cnt == 4'd1) begin
          bit_cnt_nxt  = '0;
          state_nxt    = TX;
          tx_shift_nxt = host.tx_dat[6:0];
          sda_oe_nxt   = (host.tx_dat[7] == 1'b0);
        end
      end
      WAIT_STOP: ;
      default: state_nxt = IDLE;
    endcase

    if (stop_det) begin
      state_nxt    = IDLE;
      bit_cnt_nxt  = '0;
      sda_oe_nxt   = 1'b0;
      selected_nxt = 1'b0;
      busy_nxt     = 1'b0;
    end else if (start_det) begin
      state_nxt    = ADDR;
      bit_cnt_nxt  = '0;
      sda_oe_nxt   = 1'b0;
      selected_nxt = 1'b0;
      busy_nxt     = 1'b1;
    end
  end

endmodule
